seg7_scan_display: RTL

//  Parametrised multiplexed seven-segment driver for the CPU demo tops: latches a register value on a

---
 rtl/seg7_scan_display_if.sv | 30 +++
 rtl/seg7_scan_display.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_display_if
//   Bundle between a register/bus writer and the seven-segment scan driver.
//   master : drives datain / wr_en / dec_mode, observes busy / ovf / panel pins
//   slave  : the display driver
//   datain   [DATA_W]  value to show
//   wr_en              capture strobe (ignored while busy)
//   dec_mode           0 = hex, 1 = decimal (captured with datain)
//   busy               decimal conversion in progress
//   ovf                latched value does not fit in DIGITS digits
//   grounds  [DIGITS]  one-cold digit select, bit 0 = rightmost digit
//   display  [7]       segments gfedcba
// -----------------------------------------------------------------------------
interface seg7_scan_display_if #(
   parameter int DATA_W = 16,
   parameter int DIGITS = 4
);
   logic [DATA_W-1:0] datain;
   logic              wr_en;
   logic              dec_mode;
   logic              busy;
   logic              ovf;
   logic [DIGITS-1:0] grounds;
   logic [6:0]        display;

   modport master (output datain, wr_en, dec_mode,
                   input  busy, ovf, grounds, display);
   modport slave  (input  datain, wr_en, dec_mode,
                   output busy, ovf, grounds, display);
endinterface

// File: rtl/seg7_scan_display.sv
// -----------------------------------------------------------------------------
// seg7_scan_display
//   Multiplexed seven-segment driver. Latches a value on wr_en and scans it
//   across DIGITS common-ground digits, in hex or in decimal (sequential
//   double-dabble, one bit per clock). Leading-zero blanking and overflow
//   dashes are applied at the segment decode.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_display_if.slave (datain, wr_en, dec_mode in;
//          busy, ovf, grounds, display out)
// -----------------------------------------------------------------------------
module seg7_scan_display #(
   parameter int DATA_W      = 16,
   parameter int DIGITS      = 4,
   parameter int DWELL       = 50000,
   parameter int BLANK_LZ    = 1,
   parameter int SEG_ACT_LOW = 0
) (
   input  logic clk,
   input  logic rst_n,
   seg7_scan_display_if.slave bus
);
   localparam int BW = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [6:0] UNLIT = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

   typedef enum logic {S_IDLE, S_CONV} state_t;

   state_t                  state;
   logic                    busy_q, ovf_q, sticky;
   logic [DIGITS-1:0][3:0]  dig;
   logic [DATA_W-1:0]       bin;
   logic [BW-1:0]           bcd, adj, bcd_nx, hex_val;
   logic                    carry, hex_ovf;
   logic [CW-1:0]           cc;
   logic [DW-1:0]           dw;
   logic [IW-1:0]           idx;
   logic [DIGITS-1:0]       grounds_q;
   logic [6:0]              display_q;
   logic [DIGITS-1:0][6:0]  code;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
      endcase
   endfunction

   // hex capture: low nibbles go straight to the digits, anything above them is overflow
   generate
      if (DATA_W >= BW) begin : g_wide
         assign hex_val = bus.datain[BW-1:0];
         if (DATA_W > BW) begin : g_hi
            assign hex_ovf = |bus.datain[DATA_W-1:BW];
         end else begin : g_nohi
            assign hex_ovf = 1'b0;
         end
      end else begin : g_narrow
         assign hex_val = {{(BW-DATA_W){1'b0}}, bus.datain};
         assign hex_ovf = 1'b0;
      end
   endgenerate

   // one double-dabble step: +3 on nibbles >=5, then shift the next binary bit in.
   // A 1 leaving the top nibble means the value needs more than DIGITS digits.
   always_comb begin
      adj = bcd;
      for (int k = 0; k < DIGITS; k++)
         if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
      carry  = adj[BW-1];
      bcd_nx = {adj[BW-2:0], bin[DATA_W-1]};
   end

   // capture / conversion FSM; digits and ovf only change on a hex capture
   // or on the edge where a conversion finishes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         busy_q <= 1'b0;
         ovf_q  <= 1'b0;
         sticky <= 1'b0;
         dig    <= '0;
         bin    <= '0;
         bcd    <= '0;
         cc     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.wr_en) begin
                  if (bus.dec_mode) begin
                     state  <= S_CONV;
                     busy_q <= 1'b1;
                     bin    <= bus.datain;
                     bcd    <= '0;
                     sticky <= 1'b0;
                     cc     <= '0;
                  end else begin
                     dig   <= hex_val;
                     ovf_q <= hex_ovf;
                  end
               end
            end
            S_CONV: begin
               bin    <= bin << 1;
               bcd    <= bcd_nx;
               sticky <= sticky | carry;
               cc     <= cc + 1'b1;
               if (cc == CW'(DATA_W - 1)) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
                  dig    <= bcd_nx;
                  ovf_q  <= sticky | carry;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // per-digit segment code; hz tracks "this digit and everything above is zero"
   always_comb begin
      logic hz;
      hz   = 1'b1;
      code = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         hz = hz && (dig[k] == 4'd0);
         if (ovf_q)                          code[k] = 7'h40;
         else if (BLANK_LZ != 0 && k > 0 && hz) code[k] = 7'h00;
         else                                code[k] = seg7(dig[k]);
      end
   end

   // scan: grounds and display registered together so they always switch on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dw        <= '0;
         idx       <= '0;
         grounds_q <= '1;
         display_q <= UNLIT;
      end else begin
         if (dw == DW'(DWELL - 1)) begin
            dw  <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            dw <= dw + 1'b1;
         end
         grounds_q <= ~(DIGITS'(1) << idx);
         display_q <= (SEG_ACT_LOW != 0) ? ~code[idx] : code[idx];
      end
   end

   assign bus.busy    = busy_q;
   assign bus.ovf     = ovf_q;
   assign bus.grounds = grounds_q;
   assign bus.display = display_q;
endmodule
